pm_resp_ctrl: RTL
=================

Name: pm_resp_ctrl

Overview:
- Program-memory responder that serves the program sequencer's instruction fetches: it takes a fetch address, a chip-select and a write-bar, and returns a 32-bit opcode.
- It also owns a burst loader port. An external host uses it to write instruction words into the array.
- While a load is in progress it holds the sequencer off via a stall output.
- It sits between the sequencer's PM request outputs and the PM storage array, in the clk_fetch domain.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; legal address range is 0..DEPTH-1.
- AW, 16, address width of the fetch and loader address ports.

Ports:
- clk_fetch  in  1  fetch-phase clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ps_pm_add  in  16  fetch address from the sequencer.
- ps_pm_cslt  in  1  fetch chip-select, active high.
- ps_pm_wrb  in  1  0 = read (the only legal fetch); 1 = illegal write request.
- pm_ps_op  out  32  registered opcode to the sequencer.
- pm_stallb  out  1  active-low stall to the sequencer.
- ld_start  in  1  one-cycle pulse that starts a load burst.
- ld_base  in  16  first word address of the burst; sampled with ld_start.
- ld_len  in  16  number of words in the burst; sampled with ld_start.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_ready  out  1  responder accepts a word this cycle.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse when a burst completes.
- pm_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst low):
  - State goes to IDLE.
  - pm_ps_op=32'h0 (NOP), pm_stallb=1, ld_ready=0, ld_busy=0, ld_done=0, pm_err=0.
  - Word counter cleared.
  - Array contents are NOT reset.
  - A reset during a load aborts the burst. Words already written remain; no ld_done is produced.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - Fetch is served when ps_pm_cslt=1 and ps_pm_wrb=0: pm_ps_op <= mem[ps_pm_add] at the posedge. Latency is one clk_fetch cycle.
  - ps_pm_cslt=0: pm_ps_op holds its value.
  - ld_start with ld_len!=0: latch base and len, clear the counter, go to LOAD.
  - ld_start with ld_len==0: no state change; ld_done pulses on the next cycle.
- LOAD:
  - ld_ready=1 (combinational from state). ld_busy=1.
  - On ld_valid&ld_ready: write mem[(base+cnt) mod DEPTH] <= ld_data, then cnt <= cnt+1.
  - The handshake for word cnt==len-1 moves the FSM to DRAIN.
  - ld_valid low inserts wait cycles; there is no timeout.
  - ld_start is ignored.
  - Fetches are not served and pm_ps_op holds its value.
- DRAIN (one cycle):
  - ld_ready=0. The pending fetch at ps_pm_add is performed, so pm_ps_op reflects the newly loaded contents.
  - Next state is IDLE; ld_done=1 for exactly that one cycle.
- pm_stallb and ld_busy are registered:
  - Both go low/high respectively on the posedge that enters LOAD.
  - Both return to 1/0 on the posedge that enters IDLE from DRAIN.
- Errors (all set pm_err; pm_err is cleared only by rst):
  - Fetch with ps_pm_add >= DEPTH: pm_ps_op <= 32'h0.
  - Fetch with ps_pm_cslt=1 and ps_pm_wrb=1: no read, pm_ps_op holds.
- Simultaneous events:
  - A loader write and a fetch never coincide, because fetches are blocked outside IDLE/DRAIN.
  - ld_start in the same cycle as a fetch in IDLE: the fetch completes and the FSM enters LOAD.
- Arithmetic and counters:
  - Loader address wraps modulo DEPTH; wrap is not an error.
  - cnt is 16 bits; len 16'hFFFF is legal.

Decomposition:
- Shared package pm_pkg holds:
  - state encoding enum: IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2;
  - PM_NOP = 32'h0;
  - PM_OPW = 32.
- One sub-module, pm_sram: DEPTH x 32 array with one synchronous read port and one synchronous write port, no reset.
- The FSM, counters and error logic live in pm_resp_ctrl.

Test Plan:
- Preload mem[5]=32'hA5A5_0001. In IDLE drive ps_pm_add=5, cslt=1, wrb=0 -> pm_ps_op=32'hA5A5_0001 one posedge later; pm_stallb stays 1.
- ld_start with base=16'h0010, len=3; send words 32'h11, 32'h22, 32'h33 with one ld_valid gap between each -> mem[0x10..0x12] hold those values; pm_stallb=0 for the whole burst plus DRAIN; ld_done pulses once; ld_busy falls together with ld_done.
- Load with base=DEPTH-1=1023, len=2 -> words land at 1023 and 0; pm_err stays 0.
- Fetch ps_pm_add=16'd2000 -> pm_ps_op=0, pm_err=1. Then assert cslt=1, wrb=1 -> pm_ps_op holds and pm_err remains 1 until rst.
- ld_start with len=0 -> ld_done pulses the next cycle; pm_stallb never falls; state stays IDLE.
- Assert rst low mid-burst after 2 of 4 words -> all outputs return to reset values, no ld_done; the 2 written words remain readable after reset.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and constants for the program-memory responder.
// Holds the FSM state encoding, the NOP opcode and the loader address wrap helper.
package pm_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2
  } pm_state_e;

  localparam int unsigned PM_OPW = 32;
  localparam logic [PM_OPW-1:0] PM_NOP = 32'h0;

  // Loader word address: base + offset, wrapped modulo the array depth.
  function automatic int unsigned pm_wrap(input int unsigned base, input int unsigned offs,
                                          input int unsigned depth);
    int unsigned sum;
    sum = base + offs;
    return sum % depth;
  endfunction

endpackage

// File: rtl/pm_sram.sv
// Program-memory storage: Depth x 32 array, one synchronous write port and one
// synchronous read port. Contents are not reset; read data holds when not enabled.
module pm_sram
  import pm_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  localparam int unsigned Iw = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [Iw-1:0]     waddr_i,
  input  logic [PM_OPW-1:0] wdata_i,
  input  logic              re_i,
  input  logic [Iw-1:0]     raddr_i,
  output logic [PM_OPW-1:0] rdata_o
);

  logic [PM_OPW-1:0] mem_q [Depth];
  logic [PM_OPW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pm_resp_ctrl.sv
// Program-memory responder: serves sequencer fetches with one-cycle latency and
// owns the burst loader port, stalling the sequencer while a burst is written.
module pm_resp_ctrl
  import pm_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 16
) (
  input  logic              clk_fetch,
  input  logic              rst,
  input  logic [AW-1:0]     ps_pm_add,
  input  logic              ps_pm_cslt,
  input  logic              ps_pm_wrb,
  output logic [PM_OPW-1:0] pm_ps_op,
  output logic              pm_stallb,
  input  logic              ld_start,
  input  logic [AW-1:0]     ld_base,
  input  logic [AW-1:0]     ld_len,
  input  logic              ld_valid,
  input  logic [PM_OPW-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              pm_err
);

  localparam int unsigned Iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] CntOne = AW'(1);

  pm_state_e state_q, state_d;

  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          stallb_q, stallb_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          op_zero_q, op_zero_d;
  logic          zdone_q, zdone_d;

  logic              fetch_win;
  logic              fetch_req;
  logic              add_ok;
  logic              ld_hs;
  logic              last_word;
  logic              start_load;
  logic              start_zero;
  logic              sram_re;
  logic              sram_we;
  logic [Iw-1:0]     sram_raddr;
  logic [Iw-1:0]     sram_waddr;
  logic [PM_OPW-1:0] sram_rdata;

  assign add_ok     = 32'(ps_pm_add) < DEPTH;
  assign start_load = (state_q == StIdle) && ld_start && (ld_len != '0);
  assign start_zero = (state_q == StIdle) && ld_start && (ld_len == '0);
  assign last_word  = ld_hs && (cnt_q == (len_q - CntOne));

  // FSM state register
  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_load) state_d = StLoad;
      StLoad:  if (last_word) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; fetches are only served outside LOAD so they never meet a write
  always_comb begin
    ld_ready  = 1'b0;
    fetch_win = 1'b0;
    unique case (state_q)
      StIdle:  fetch_win = 1'b1;
      StLoad:  ld_ready = 1'b1;
      StDrain: fetch_win = 1'b1;
      default: fetch_win = 1'b0;
    endcase
  end

  assign ld_hs     = ld_ready && ld_valid;
  assign fetch_req = fetch_win && ps_pm_cslt && !ps_pm_wrb;
  assign ld_done   = (state_q == StDrain) || zdone_q;

  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    stallb_d  = stallb_q;
    busy_d    = busy_q;
    err_d     = err_q;
    op_zero_d = op_zero_q;
    zdone_d   = start_zero;

    if (start_load) begin
      base_d   = ld_base;
      len_d    = ld_len;
      cnt_d    = '0;
      stallb_d = 1'b0;
      busy_d   = 1'b1;
    end
    if (ld_hs) begin
      cnt_d = cnt_q + CntOne;
    end
    if (state_q == StDrain) begin
      stallb_d = 1'b1;
      busy_d   = 1'b0;
    end

    if (fetch_win && ps_pm_cslt && (ps_pm_wrb || !add_ok)) begin
      err_d = 1'b1;
    end
    // Out-of-range fetches return NOP without touching the array
    if (fetch_req) begin
      op_zero_d = !add_ok;
    end
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      stallb_q  <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      op_zero_q <= 1'b1;
      zdone_q   <= 1'b0;
    end else begin
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      stallb_q  <= stallb_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      op_zero_q <= op_zero_d;
      zdone_q   <= zdone_d;
    end
  end

  assign sram_re    = fetch_req && add_ok;
  assign sram_raddr = ps_pm_add[Iw-1:0];
  assign sram_we    = ld_hs;
  assign sram_waddr = Iw'(pm_wrap(32'(base_q), 32'(cnt_q), DEPTH));

  pm_sram #(
    .Depth(DEPTH)
  ) u_sram (
    .clk_i  (clk_fetch),
    .we_i   (sram_we),
    .waddr_i(sram_waddr),
    .wdata_i(ld_data),
    .re_i   (sram_re),
    .raddr_i(sram_raddr),
    .rdata_o(sram_rdata)
  );

  assign pm_ps_op  = op_zero_q ? PM_NOP : sram_rdata;
  assign pm_stallb = stallb_q;
  assign ld_busy   = busy_q;
  assign pm_err    = err_q;

endmodule
